// File: rtl/i2s_tx_fifo_p.sv
// i2s_tx_fifo_p
// I2S transmit buffer and serializer. Frames (L/R sample pairs) are queued
// in a DEPTH-entry FIFO on clk and shifted out MSB first on sd/ws, one bit
// per sck_en strobe. Philips I2S and left-justified framing, 16/24/32-bit
// words, stereo or mono (din_l in both slots). When the FIFO runs dry while
// transmitting, an all-zero frame is inserted so framing never stalls.
//
// Optional build macro: I2S_TX_UNDERRUN_CNT_EN
//   defined   -> adds underrun_cnt, a saturating 16-bit count of underruns
//   undefined -> no counter, no port
//
// state | meaning
// IDLE  | not transmitting, sd=0 ws=0, waits for tx_en with data queued
// LEFT  | shifting the left slot word (ws=0)
// RIGHT | shifting the right slot word (ws=1); frame boundary at its last bit

module i2s_tx_fifo_p #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sck_en,
    input  logic                     tx_en,
    input  logic                     wen,
    input  logic [31:0]              din_l,
    input  logic [31:0]              din_r,
    input  logic                     stereo,
    input  logic [1:0]               standard,
    input  logic [1:0]               word_size,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underrun,
    output logic                     sd,
    output logic                     ws,
    output logic                     busy
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]              underrun_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [31:0] mem_l [DEPTH];
    logic [31:0] mem_r [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        push;
    logic        pop;
    logic [31:0] rd_l;
    logic [31:0] rd_r;

    // Flags come from the pre-edge pointers, so a pop in the same cycle
    // never frees room for a write, and a fresh write is never popped at once.
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign empty = (wptr == rptr);
    assign level = wptr - rptr;
    assign push  = wen && !full;
    assign rd_l  = mem_l[rptr[AW-1:0]];
    assign rd_r  = mem_r[rptr[AW-1:0]];

    // Frame storage; contents after reset are don't-care, so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wptr[AW-1:0]] <= din_l;
            mem_r[wptr[AW-1:0]] <= din_r;
        end
    end

    // Write/read pointers with wrap bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // Dropped-write indication, one cycle per dropped write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else begin
            overflow <= wen && full;
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_nxt;
    logic        load_frame;
    logic        load_zero;
    logic        emit;
    logic [4:0]  bit_cnt;
    logic [4:0]  cfg_wm1;
    logic        cfg_lj;
    logic [31:0] word_l;
    logic [31:0] word_r;
    logic        prev_bit;
    logic        slot_bit;

    // Highest bit index of a slot for a given word_size code.
    function automatic logic [4:0] wm1_of(input logic [1:0] sel);
        case (sel)
            2'b00:   wm1_of = 5'd15;
            2'b01:   wm1_of = 5'd23;
            default: wm1_of = 5'd31;
        endcase
    endfunction

    assign busy     = (state != IDLE);
    assign slot_bit = (state == LEFT) ? word_l[bit_cnt] : word_r[bit_cnt];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, FIFO pop and frame-load decisions; all gated by sck_en.
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        load_frame = 1'b0;
        load_zero  = 1'b0;
        emit       = 1'b0;
        if (sck_en) begin
            case (state)
                IDLE: begin
                    if (tx_en && !empty) begin
                        pop        = 1'b1;
                        load_frame = 1'b1;
                        state_nxt  = LEFT;
                    end
                end
                LEFT: begin
                    emit = 1'b1;
                    if (bit_cnt == 5'd0) begin
                        state_nxt = RIGHT;
                    end
                end
                RIGHT: begin
                    emit = 1'b1;
                    if (bit_cnt == 5'd0) begin
                        if (!tx_en) begin
                            state_nxt = IDLE;
                        end else begin
                            load_frame = 1'b1;
                            state_nxt  = LEFT;
                            if (!empty) begin
                                pop = 1'b1;
                            end else begin
                                load_zero = 1'b1;
                            end
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Frame/config latch, bit counter and registered serial outputs. On a
    // frame-end load the last bit of the old frame is emitted with the old
    // configuration while the new frame is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_l   <= '0;
            word_r   <= '0;
            bit_cnt  <= '0;
            cfg_wm1  <= '0;
            cfg_lj   <= 1'b0;
            prev_bit <= 1'b0;
            sd       <= 1'b0;
            ws       <= 1'b0;
        end else begin
            if (load_frame) begin
                word_l  <= load_zero ? 32'd0 : rd_l;
                word_r  <= load_zero ? 32'd0 : (stereo ? rd_r : rd_l);
                cfg_lj  <= (standard != 2'b00);
                cfg_wm1 <= wm1_of(word_size);
                bit_cnt <= wm1_of(word_size);
            end else if (emit) begin
                bit_cnt <= (bit_cnt == 5'd0) ? cfg_wm1 : bit_cnt - 5'd1;
            end

            if (emit) begin
                ws       <= (state == RIGHT);
                sd       <= cfg_lj ? slot_bit : prev_bit;
                prev_bit <= slot_bit;
            end else if (sck_en && (state == IDLE)) begin
                ws       <= 1'b0;
                sd       <= 1'b0;
                prev_bit <= 1'b0;
            end
        end
    end

    // Underrun pulse accompanies each inserted zero frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else begin
            underrun <= load_zero;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // Saturating underrun counter, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (load_zero && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule
